// File: rtl/decode_regfile.sv
// Y86-64 SEQ decode and write-back stage: register ID selection,
// combinational register file reads, and write-back that stops for good
// after a faulting instruction.
module decode_regfile #(
    parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_0200,
    parameter logic [3:0]  RNONE    = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    input  logic        stat_ok,
    input  logic [3:0]  dbg_sel,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] dbg_val,
    output logic        halted
);

    // Y86-64 instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_RSP    = 4'h4;
    localparam int         NUM_REGS = 15;

    logic [63:0] regs [0:NUM_REGS-1];
    logic        write_ok;

    // Source register IDs: operands, or %rsp for stack pops
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = rA;
            I_RET, I_POPQ:                      srcA = R_RSP;
            default:                            srcA = RNONE;
        endcase
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcB = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcB = R_RSP;
            default:                            srcB = RNONE;
        endcase
    end

    // Destination register IDs; a conditional move that fails writes nothing
    always_comb begin
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            I_IRMOVQ, I_OPQ:                    dstE = rB;
            I_RRMOVQ:                           dstE = cnd ? rB : RNONE;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     dstE = R_RSP;
            default:                            dstE = RNONE;
        endcase
        case (icode)
            I_MRMOVQ, I_POPQ:                   dstM = rA;
            default:                            dstM = RNONE;
        endcase
    end

    // Read ports; ID F matches no entry and therefore reads as zero
    always_comb begin
        valA    = 64'h0;
        valB    = 64'h0;
        dbg_val = 64'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (srcA == 4'(i))    valA    = regs[i];
            if (srcB == 4'(i))    valB    = regs[i];
            if (dbg_sel == 4'(i)) dbg_val = regs[i];
        end
    end

    assign write_ok = wb_en && stat_ok && !halted;

    // Register write-back; the M port is checked first so popq %rsp keeps valM
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                regs[i] <= (i == 4) ? RSP_INIT : 64'h0;
            end else if (write_ok) begin
                if (dstM == 4'(i)) begin
                    regs[i] <= valM;
                end else if (dstE == 4'(i)) begin
                    regs[i] <= valE;
                end
            end
        end
    end

    // Sticky halt flag, set by a write-back attempt from a faulting instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (wb_en && !stat_ok) begin
            halted <= 1'b1;
        end
    end

    // Instruction codes that the decode tables treat as "no registers"
    logic unused_codes;
    assign unused_codes = (icode == I_HALT) | (icode == I_NOP) | (icode == I_JXX);

endmodule

// File: tb/tb_decode_regfile.sv
// Self-checking bench for decode_regfile: directed scenarios followed by
// randomized traffic compared against a behavioural register file model.
module tb_decode_regfile;

    logic        clk;
    logic        rst;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        wb_en;
    logic        stat_ok;
    logic [3:0]  dbg_sel;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] dbg_val;
    logic        halted;

    int checks;
    int failures;

    logic [63:0] model_regs [0:14];
    logic        model_halted;

    decode_regfile dut (
        .clk     (clk),
        .rst     (rst),
        .icode   (icode),
        .rA      (rA),
        .rB      (rB),
        .cnd     (cnd),
        .valE    (valE),
        .valM    (valM),
        .wb_en   (wb_en),
        .stat_ok (stat_ok),
        .dbg_sel (dbg_sel),
        .srcA    (srcA),
        .srcB    (srcB),
        .dstE    (dstE),
        .dstM    (dstM),
        .valA    (valA),
        .valB    (valB),
        .dbg_val (dbg_val),
        .halted  (halted)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference ID selection, taken straight from the Y86 decode tables
    function automatic logic [3:0] refSrcA(input logic [3:0] ic, input logic [3:0] a);
        if (ic inside {4'd2, 4'd4, 4'd6, 4'd10}) return a;
        if (ic inside {4'd9, 4'd11}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] refSrcB(input logic [3:0] ic, input logic [3:0] b);
        if (ic inside {4'd4, 4'd5, 4'd6}) return b;
        if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] refDstE(input logic [3:0] ic, input logic [3:0] b, input logic c);
        if (ic inside {4'd3, 4'd6}) return b;
        if (ic == 4'd2) return c ? b : 4'hF;
        if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] refDstM(input logic [3:0] ic, input logic [3:0] a);
        if (ic inside {4'd5, 4'd11}) return a;
        return 4'hF;
    endfunction

    function automatic logic [63:0] refRead(input logic [3:0] id);
        if (id == 4'hF) return 64'h0;
        return model_regs[id];
    endfunction

    // Drive one set of inputs
    task automatic applyStimulus(input logic r, input logic [3:0] ic, input logic [3:0] a,
                                 input logic [3:0] b, input logic c, input logic [63:0] e,
                                 input logic [63:0] m, input logic we, input logic ok,
                                 input logic [3:0] dsel);
        rst = r; icode = ic; rA = a; rB = b; cnd = c;
        valE = e; valM = m; wb_en = we; stat_ok = ok; dbg_sel = dsel;
    endtask

    // Compare every output against the model for the current inputs
    task automatic checkAll(input string tag);
        logic [3:0] eA;
        logic [3:0] eB;
        eA = refSrcA(icode, rA);
        eB = refSrcB(icode, rB);
        checkOutput({tag, ".srcA"}, {60'h0, srcA}, {60'h0, eA});
        checkOutput({tag, ".srcB"}, {60'h0, srcB}, {60'h0, eB});
        checkOutput({tag, ".dstE"}, {60'h0, dstE}, {60'h0, refDstE(icode, rB, cnd)});
        checkOutput({tag, ".dstM"}, {60'h0, dstM}, {60'h0, refDstM(icode, rA)});
        checkOutput({tag, ".valA"}, valA, refRead(eA));
        checkOutput({tag, ".valB"}, valB, refRead(eB));
        checkOutput({tag, ".dbg"}, dbg_val, refRead(dbg_sel));
        checkOutput({tag, ".halted"}, {63'h0, halted}, {63'h0, model_halted});
    endtask

    // Advance one clock edge and apply the architectural effect to the model
    task automatic stepClock();
        logic [3:0] de;
        logic [3:0] dm;
        @(posedge clk);
        de = refDstE(icode, rB, cnd);
        dm = refDstM(icode, rA);
        if (rst) begin
            for (int i = 0; i < 15; i++) model_regs[i] = (i == 4) ? 64'h200 : 64'h0;
            model_halted = 1'b0;
        end else if (wb_en && !model_halted) begin
            if (!stat_ok) begin
                model_halted = 1'b1;
            end else begin
                if (de != 4'hF) model_regs[de] = valE;
                if (dm != 4'hF) model_regs[dm] = valM;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        model_halted = 1'b0;
        for (int i = 0; i < 15; i++) model_regs[i] = 64'h0;

        applyStimulus(1, 4'h1, 4'hF, 4'hF, 0, 64'h0, 64'h0, 0, 1, 4'h0);
        @(negedge clk);
        stepClock();

        // Reset values seen through the debug port
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            #1;
            checkOutput("reset_dbg", dbg_val, (i == 4) ? 64'h200 : 64'h0);
        end
        checkOutput("reset_halted", {63'h0, halted}, 64'h0);

        // irmovq writes rB from valE
        applyStimulus(0, 4'd3, 4'hF, 4'd2, 0, 64'h1234, 64'h0, 1, 1, 4'd2);
        #1;
        checkOutput("irmovq_srcA", {60'h0, srcA}, 64'hF);
        checkOutput("irmovq_srcB", {60'h0, srcB}, 64'hF);
        checkOutput("irmovq_dstM", {60'h0, dstM}, 64'hF);
        checkOutput("irmovq_dstE", {60'h0, dstE}, 64'h2);
        stepClock();
        wb_en = 0;
        #1;
        checkOutput("irmovq_reg2", dbg_val, 64'h1234);

        // Conditional move, not taken then taken
        applyStimulus(0, 4'd2, 4'd1, 4'd3, 0, 64'h77, 64'h0, 1, 1, 4'd3);
        #1;
        checkOutput("cmov_nt_dstE", {60'h0, dstE}, 64'hF);
        stepClock();
        #1;
        checkOutput("cmov_nt_reg3", dbg_val, 64'h0);
        cnd = 1; valE = 64'h5;
        #1;
        checkOutput("cmov_t_dstE", {60'h0, dstE}, 64'h3);
        stepClock();
        wb_en = 0;
        #1;
        checkOutput("cmov_t_reg3", dbg_val, 64'h5);

        // popq %rsp: memory value wins over the incremented stack pointer
        applyStimulus(0, 4'd11, 4'd4, 4'hF, 0, 64'h208, 64'hBEEF, 1, 1, 4'd4);
        #1;
        checkOutput("popq_srcA", {60'h0, srcA}, 64'h4);
        checkOutput("popq_srcB", {60'h0, srcB}, 64'h4);
        checkOutput("popq_dstE", {60'h0, dstE}, 64'h4);
        checkOutput("popq_dstM", {60'h0, dstM}, 64'h4);
        stepClock();
        wb_en = 0;
        #1;
        checkOutput("popq_reg4", dbg_val, 64'hBEEF);

        // Faulting write-back freezes the register file until reset
        applyStimulus(0, 4'd6, 4'd1, 4'd0, 0, 64'h7, 64'h0, 1, 0, 4'd0);
        stepClock();
        stat_ok = 1; wb_en = 0;
        #1;
        checkOutput("fault_halted", {63'h0, halted}, 64'h1);
        checkOutput("fault_reg0", dbg_val, 64'h0);
        applyStimulus(0, 4'd3, 4'hF, 4'd0, 0, 64'h9, 64'h0, 1, 1, 4'd0);
        stepClock();
        wb_en = 0;
        #1;
        checkOutput("halted_reg0", dbg_val, 64'h0);
        checkOutput("halted_sticky", {63'h0, halted}, 64'h1);
        rst = 1;
        stepClock();
        rst = 0;
        #1;
        checkOutput("rst_clears_halt", {63'h0, halted}, 64'h0);

        // Reset beats a simultaneous write to %rsp
        applyStimulus(1, 4'd3, 4'hF, 4'd4, 0, 64'd99, 64'h0, 1, 1, 4'd4);
        stepClock();
        applyStimulus(0, 4'd2, 4'hF, 4'd1, 0, 64'h0, 64'h0, 0, 1, 4'd4);
        #1;
        checkOutput("rst_wins_reg4", dbg_val, 64'h200);
        checkOutput("rnone_valA", valA, 64'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          {$urandom, $urandom}, {$urandom, $urandom},
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) != 0),
                          4'($urandom_range(0, 15)));
            #1;
            checkAll("rand");
            stepClock();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
